bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: shared data bus width in bits.
REQ-002 SHALL have parameter IDW, default 3: register-select width; NREGS = 2**IDW registers on the bus.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: a transfer request is presented.
REQ-006 SHALL have port req_ready, output, 1: the controller can accept a request this cycle.
REQ-007 SHALL have port req_src, input, IDW: index of the source register.
REQ-008 SHALL have port req_dst, input, IDW: index of the destination register.
REQ-009 SHALL have port bus_in, input, WIDTH: sampled value of the shared bus.
REQ-010 SHALL have port oe, output, NREGS: per-register output enables, at most one bit high.
REQ-011 SHALL have port ld, output, NREGS: per-register load strobes, at most one bit high.
REQ-012 SHALL have port last_data, output, WIDTH: bus value captured by the last completed transfer.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on transfer completion.
REQ-014 SHALL have port err, output, 1: one-cycle pulse on a rejected request.
REQ-015 SHALL have port xfer_count, output, 8: count of completed transfers.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, LOAD and TURN, with all outputs registered.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-018 SHALL latch req_src and req_dst at acceptance; later changes to the request inputs do not affect the transfer in flight.
REQ-019 SHALL, on acceptance with src != dst, move IDLE->DRIVE: oe[src]=1, ld all 0 (bus setup cycle).
REQ-020 SHALL move DRIVE->LOAD: oe[src]=1 held, ld[dst]=1, last_data <= bus_in at the end of LOAD.
REQ-021 SHALL move LOAD->TURN: oe=0, ld=0, done=1 for exactly this cycle, xfer_count increments by 1 (bus turnaround cycle).
REQ-022 SHALL move TURN->IDLE unconditionally, giving a throughput of one transfer per 4 cycles.
REQ-023 SHALL, on acceptance with src == dst, stay in IDLE, assert err=1 for one cycle, leave oe, ld, done, last_data and xfer_count unchanged, and keep req_ready=1.
REQ-024 SHALL never assert oe and ld of the same index together, and never assert more than one oe bit.
REQ-025 SHALL wrap xfer_count modulo 256 (255 -> 0 on the next completion).
REQ-026 SHALL ignore req_valid in DRIVE, LOAD and TURN; no request is queued.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, enter IDLE, clear oe, ld, last_data, done, err and xfer_count to 0, and set req_ready=1 the following cycle.
REQ-028 SHALL honour reset in any state, including mid-transfer; the aborted transfer is not counted, done does not pulse, and last_data is cleared.
REQ-029 SHALL drive req_ready=0 while reset=0.

Verification
REQ-030 SHALL be verified by: reset, then a request src=2, dst=5 with bus_in=4'b1010 -> oe=8'b0000_0100 in cycles 1-2, ld=8'b0010_0000 in cycle 2, done in cycle 3, last_data=4'b1010, xfer_count=1.
REQ-031 SHALL be verified by: a request src=3, dst=3 -> err pulses for 1 cycle, oe and ld stay 0, xfer_count unchanged.
REQ-032 SHALL be verified by: req_valid held high continuously -> accepts spaced exactly 4 cycles apart, req_ready=0 in DRIVE, LOAD and TURN.
REQ-033 SHALL be verified by: reset=0 during LOAD -> next cycle oe=0, ld=0, last_data=0, xfer_count=0, no done pulse.
REQ-034 SHALL be verified by: 256 valid transfers -> xfer_count returns to 0 and the oe/ld one-hot checks hold every cycle.
REQ-035 SHALL be verified by: req_src and req_dst changed during DRIVE -> strobes still use the indices latched at acceptance.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bus_xfer_ctrl
//  Purpose  : Sequences register-to-register moves over a shared data bus.
//             Each move runs DRIVE (source drives bus), LOAD (destination
//             strobes), then TURN (bus released, completion pulse).
//             A request whose source equals its destination is rejected
//             with a one-cycle err pulse.
//  Ports    : clock       - rising-edge clock
//             reset       - synchronous, active-low reset
//             req_valid   - request presented
//             req_ready   - controller accepts a request this cycle
//             req_src     - source register index
//             req_dst     - destination register index
//             bus_in      - sampled shared bus value
//             oe          - per-register output enables (at most one high)
//             ld          - per-register load strobes (at most one high)
//             last_data   - bus value captured by the last completed move
//             done        - one-cycle completion pulse
//             err         - one-cycle rejected-request pulse
//             xfer_count  - completed moves, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
  parameter int WIDTH = 4,
  parameter int IDW   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDW-1:0]       req_src,
  input  logic [IDW-1:0]       req_dst,
  input  logic [WIDTH-1:0]     bus_in,
  output logic [(2**IDW)-1:0]  oe,
  output logic [(2**IDW)-1:0]  ld,
  output logic [WIDTH-1:0]     last_data,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           xfer_count
);

  localparam int NREGS = 2**IDW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] TURN  = 2'd3;

  localparam logic [NREGS-1:0] c_one = {{(NREGS-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_src;
  logic [IDW-1:0]   r_dst;
  logic [NREGS-1:0] r_oe;
  logic [NREGS-1:0] r_ld;
  logic [WIDTH-1:0] r_last;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_count;
  logic             r_ready;
  logic             w_accept;

  // r_ready is only ever high while IDLE, so this is the acceptance handshake.
  assign w_accept = req_valid && r_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_oe    <= '0;
      r_ld    <= '0;
      r_last  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 8'd0;
      // Held low while in reset; rises on the first edge after release.
      r_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && (req_src == req_dst)) begin
            // Rejected: nothing moves, controller stays available.
            r_err   <= 1'b1;
            r_ready <= 1'b1;
          end else if (w_accept) begin
            r_state <= DRIVE;
            r_src   <= req_src;
            r_dst   <= req_dst;
            r_oe    <= c_one << req_src;
            r_ld    <= '0;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        DRIVE: begin
          // Source keeps driving; destination strobes while bus is settled.
          r_state <= LOAD;
          r_oe    <= c_one << r_src;
          r_ld    <= c_one << r_dst;
        end
        LOAD: begin
          r_state <= TURN;
          r_oe    <= '0;
          r_ld    <= '0;
          r_last  <= bus_in;
          r_done  <= 1'b1;
          r_count <= r_count + 8'd1;
        end
        TURN: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_oe    <= '0;
          r_ld    <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign oe         = r_oe;
  assign ld         = r_ld;
  assign last_data  = r_last;
  assign done       = r_done;
  assign err        = r_err;
  assign xfer_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_xfer_ctrl
//  Purpose  : Self-checking bench for bus_xfer_ctrl. A transaction-level
//             model (cycles elapsed since acceptance) predicts every output
//             each cycle; directed sequences add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;

  localparam int WIDTH = 4;
  localparam int IDW   = 3;
  localparam int NREGS = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [IDW-1:0]   req_src = '0;
  logic [IDW-1:0]   req_dst = '0;
  logic [WIDTH-1:0] bus_in = '0;
  logic [NREGS-1:0] oe;
  logic [NREGS-1:0] ld;
  logic [WIDTH-1:0] last_data;
  logic             done;
  logic             err;
  logic [7:0]       xfer_count;

  bus_xfer_ctrl #(.WIDTH(WIDTH), .IDW(IDW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .bus_in     (bus_in),
    .oe         (oe),
    .ld         (ld),
    .last_data  (last_data),
    .done       (done),
    .err        (err),
    .xfer_count (xfer_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: age = cycles since acceptance (0 = no move in flight).
  int         m_age   = 0;
  bit         m_ready = 0;
  bit         m_err   = 0;
  int         m_src   = 0;
  int         m_dst   = 0;
  int         m_last  = 0;
  int         m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic compare_model();
    logic [NREGS-1:0] e_oe;
    logic [NREGS-1:0] e_ld;
    e_oe = '0;
    e_ld = '0;
    if (m_age == 1 || m_age == 2) e_oe[m_src] = 1'b1;
    if (m_age == 2) e_ld[m_dst] = 1'b1;
    chk("ready", 32'(req_ready), 32'(m_ready));
    chk("oe", 32'(oe), 32'(e_oe));
    chk("ld", 32'(ld), 32'(e_ld));
    chk("done", 32'(done), 32'(m_age == 3));
    chk("err", 32'(err), 32'(m_err));
    chk("last_data", 32'(last_data), 32'(m_last));
    chk("xfer_count", 32'(xfer_count), 32'(m_count));
    chk("oe_onehot", 32'($countones(oe) <= 1), 32'd1);
    chk("ld_onehot", 32'($countones(ld) <= 1), 32'd1);
    chk("oe_ld_overlap", 32'(oe & ld), 32'd0);
  endtask

  task automatic model_edge(input bit v, input int s, input int d, input int b, input bit rn);
    if (!rn) begin
      m_age = 0; m_ready = 0; m_err = 0; m_last = 0; m_count = 0;
      return;
    end
    m_err = 0;
    if (m_age == 0) begin
      if (v && m_ready && s == d) begin
        m_err = 1; m_ready = 1;
      end else if (v && m_ready) begin
        m_age = 1; m_src = s; m_dst = d; m_ready = 0;
      end else begin
        m_ready = 1;
      end
    end else if (m_age == 2) begin
      m_last  = b;
      m_count = (m_count + 1) % 256;
      m_age   = 3;
    end else if (m_age == 3) begin
      m_age = 0; m_ready = 1;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  // One clock: check outputs vs model, drive inputs, advance model at the edge.
  task automatic tick(input bit v, input int s, input int d, input int b, input bit rn);
    @(negedge clock);
    compare_model();
    req_valid = v;
    req_src   = IDW'(s);
    req_dst   = IDW'(d);
    bus_in    = WIDTH'(b);
    reset     = rn;
    @(posedge clock);
    model_edge(v, s, d, b, rn);
    #1;
  endtask

  initial begin
    int last_rdy;
    int dones;
    int cyc;
    int s;
    int d;

    // Reset state
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    tick(0, 0, 0, 0, 1);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic move src=2 dst=5, bus=1010
    tick(1, 2, 5, 4'b1010, 1);
    chk("c1_oe", 32'(oe), 32'h04);
    chk("c1_ld", 32'(ld), 32'h00);
    tick(0, 0, 0, 4'b1010, 1);
    chk("c2_oe", 32'(oe), 32'h04);
    chk("c2_ld", 32'(ld), 32'h20);
    tick(0, 0, 0, 4'b1010, 1);
    chk("c3_done", 32'(done), 32'd1);
    chk("c3_oe", 32'(oe), 32'h00);
    chk("c3_last", 32'(last_data), 32'hA);
    chk("c3_count", 32'(xfer_count), 32'd1);
    tick(0, 0, 0, 0, 1);
    chk("c4_done", 32'(done), 32'd0);
    chk("c4_ready", 32'(req_ready), 32'd1);

    // Rejected request src=dst=3
    tick(1, 3, 3, 0, 1);
    chk("rej_err", 32'(err), 32'd1);
    chk("rej_oe", 32'(oe), 32'd0);
    chk("rej_ready", 32'(req_ready), 32'd1);
    chk("rej_count", 32'(xfer_count), 32'd1);
    tick(0, 0, 0, 0, 1);
    chk("rej_err_clr", 32'(err), 32'd0);

    // req_valid held high: accepts exactly 4 cycles apart
    last_rdy = -1;
    for (int i = 0; i < 16; i++) begin
      if (req_ready) begin
        if (last_rdy >= 0) chk("accept_gap", 32'(i - last_rdy), 32'd4);
        last_rdy = i;
      end
      s = $urandom_range(0, 7);
      tick(1, s, (s + 1 + $urandom_range(0, 6)) % 8, $urandom_range(0, 15), 1);
    end
    while (!req_ready) tick(0, 0, 0, 0, 1);

    // Indices latched at acceptance
    tick(1, 1, 6, 0, 1);
    tick(1, 4, 0, 0, 1);
    chk("latch_ld", 32'(ld), 32'h40);
    chk("latch_oe", 32'(oe), 32'h02);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);

    // Reset during LOAD
    tick(1, 0, 7, 5, 1);
    tick(0, 0, 0, 5, 1);
    tick(0, 0, 0, 5, 0);
    chk("abort_oe", 32'(oe), 32'd0);
    chk("abort_ld", 32'(ld), 32'd0);
    chk("abort_last", 32'(last_data), 32'd0);
    chk("abort_count", 32'(xfer_count), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick(0, 0, 0, 0, 1);
    chk("abort_done_next", 32'(done), 32'd0);

    // 256 completions wrap the counter to 0
    dones = 0;
    cyc = 0;
    while (dones < 256 && cyc < 1500) begin
      s = $urandom_range(0, 7);
      tick(1, s, (s + 1 + $urandom_range(0, 6)) % 8, $urandom_range(0, 15), 1);
      if (done === 1'b1) dones++;
      cyc++;
    end
    chk("wrap_dones", 32'(dones), 32'd256);
    chk("wrap_count", 32'(xfer_count), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 15), $urandom_range(0, 49) != 0);
    end
    tick(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
